// File: rtl/tulip_audio_pkg.sv
// Shared constants and types for the audio output path.
// Default sample width, slot length and BCLK divider for a 12.288 MHz clk.
package tulip_audio_pkg;

    localparam int C_ADC_DWIDTH    = 24;
    localparam int C_I2S_SLOT_BITS = 32;
    localparam int C_I2S_BCLK_DIV  = 2;

    typedef logic signed [C_ADC_DWIDTH-1:0] sample_t;

    // clk cycles in one stereo frame: two slots, two BCLK half-periods per bit
    function automatic int frame_clks(input int slot_bits, input int bclk_div);
        return 2 * slot_bits * 2 * bclk_div;
    endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// I2S bit clock divider: toggles bclk every G_BCLK_DIV clk cycles and
// flags the clk cycle whose edge takes bclk from high to low.
module i2s_bclk_gen
    import tulip_audio_pkg::*;
#(
    parameter int G_BCLK_DIV = C_I2S_BCLK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic bclk,
    output logic fe_strobe
);

    localparam int            CW   = (G_BCLK_DIV > 1) ? $clog2(G_BCLK_DIV) : 1;
    localparam logic [CW-1:0] C_TC = CW'(G_BCLK_DIV - 1);

    logic [CW-1:0] div_cnt;
    logic          tc;

    assign tc        = (div_cnt == C_TC);
    // Combinational so the top updates lrclk/sdata on the same edge bclk falls
    assign fe_strobe = enable & ~reset & tc & bclk;

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (tc) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_dac_tx.sv
// Stereo I2S transmitter for a mono sample stream: one sample per frame,
// duplicated on both slots, with a one-entry holding register and sticky underflow.
module i2s_dac_tx
    import tulip_audio_pkg::*;
#(
    parameter int G_DWIDTH    = C_ADC_DWIDTH,
    parameter int G_SLOT_BITS = C_I2S_SLOT_BITS,
    parameter int G_BCLK_DIV  = C_I2S_BCLK_DIV
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                mute,
    input  logic [G_DWIDTH-1:0] din,
    input  logic                din_valid,
    output logic                din_ready,
    output logic                i2s_bclk,
    output logic                i2s_lrclk,
    output logic                i2s_sdata,
    output logic                underflow,
    input  logic                underflow_clear
);

    localparam int            BW         = $clog2(2 * G_SLOT_BITS);
    localparam int            IW         = (G_DWIDTH > 1) ? $clog2(G_DWIDTH) : 1;
    localparam logic [BW-1:0] C_BIT_LAST = BW'(2 * G_SLOT_BITS - 1);
    localparam logic [BW-1:0] C_SLOT     = BW'(G_SLOT_BITS);
    localparam logic [BW-1:0] C_DW       = BW'(G_DWIDTH);

    logic                       fe_strobe;
    logic [BW-1:0]              bit_cnt;
    logic [BW-1:0]              bit_nxt;
    logic [BW-1:0]              slot_k;
    logic                       lr_nxt;
    logic                       sd_nxt;
    logic                       frame_load;
    logic                       accept;
    logic                       hold_full;
    logic                       hold_full_nxt;
    logic signed [G_DWIDTH-1:0] hold_data;
    logic signed [G_DWIDTH-1:0] out_sample;

    i2s_bclk_gen #(
        .G_BCLK_DIV (G_BCLK_DIV)
    ) u_bclk_gen (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .bclk      (i2s_bclk),
        .fe_strobe (fe_strobe)
    );

    // Bit position and serial data for the BCLK period that starts at the next FE
    always_comb begin
        bit_nxt = (bit_cnt == C_BIT_LAST) ? '0 : bit_cnt + 1'b1;
        lr_nxt  = (bit_nxt >= C_SLOT);
        slot_k  = lr_nxt ? (bit_nxt - C_SLOT) : bit_nxt;
        sd_nxt  = 1'b0;
        if ((slot_k != '0) && (slot_k <= C_DW)) begin
            sd_nxt = out_sample[IW'(G_DWIDTH - int'(slot_k))];
        end
    end

    // Holding register handshake; a load never bypasses a same-cycle accept
    always_comb begin
        accept        = din_valid & din_ready;
        frame_load    = fe_strobe & (bit_nxt == '0);
        hold_full_nxt = hold_full;
        if (accept) begin
            hold_full_nxt = 1'b1;
        end else if (frame_load) begin
            hold_full_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            bit_cnt    <= C_BIT_LAST;
            i2s_lrclk  <= 1'b0;
            i2s_sdata  <= 1'b0;
            hold_full  <= 1'b0;
            din_ready  <= 1'b0;
            underflow  <= 1'b0;
            out_sample <= '0;
        end else begin
            hold_full <= hold_full_nxt;
            din_ready <= ~hold_full_nxt;
            if (fe_strobe) begin
                bit_cnt   <= bit_nxt;
                i2s_lrclk <= lr_nxt;
                i2s_sdata <= sd_nxt;
            end
            if (frame_load) begin
                out_sample <= (hold_full && !mute) ? hold_data : '0;
            end
            if (frame_load && !hold_full) begin
                underflow <= 1'b1;
            end else if (underflow_clear) begin
                underflow <= 1'b0;
            end
        end
    end

    // Sample payload; validity is tracked by hold_full alone
    always_ff @(posedge clk) begin
        if (accept) begin
            hold_data <= din;
        end
    end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed bench for i2s_dac_tx: frame tables plus reset, back-pressure,
// mute and mid-frame reset sequences.
module tb_i2s_dac_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        mute;
    logic [23:0] din;
    logic        din_valid;
    logic        din_ready;
    logic        i2s_bclk;
    logic        i2s_lrclk;
    logic        i2s_sdata;
    logic        underflow;
    logic        underflow_clear;

    int checks   = 0;
    int failures = 0;

    i2s_dac_tx dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .mute            (mute),
        .din             (din),
        .din_valid       (din_valid),
        .din_ready       (din_ready),
        .i2s_bclk        (i2s_bclk),
        .i2s_lrclk       (i2s_lrclk),
        .i2s_sdata       (i2s_sdata),
        .underflow       (underflow),
        .underflow_clear (underflow_clear)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        push;
        logic [23:0] val;
        logic        mute_next;
        logic        clr;
        logic [23:0] exp_val;
        logic        exp_uf;
    } vec_t;

    vec_t        vecs[7];
    logic [63:0] bits;
    logic [63:0] lrs;
    int          cyc;
    logic        per_ok;
    logic [63:0] fr[4];
    logic        stream_on;
    logic        acc_pend;
    int          accepts;
    int          rises;
    logic        prev_b;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] frame_of(input logic [23:0] s);
        return {1'b0, s, 7'b0, 1'b0, s, 7'b0};
    endfunction

    // Records sdata/lrclk at the next 64 BCLK rising edges
    task automatic capture(output logic [63:0] b, output logic [63:0] l,
                           output int c, output logic ok);
        int   n;
        int   last;
        logic pb;
        n    = 0;
        c    = 0;
        last = 0;
        ok   = 1'b1;
        b    = '0;
        l    = '0;
        pb   = i2s_bclk;
        while (n < 64 && c < 400) begin
            @(negedge clk);
            c++;
            if (i2s_bclk && !pb) begin
                b[63-n] = i2s_sdata;
                l[63-n] = i2s_lrclk;
                if (n > 0 && (c - last) != 4) ok = 1'b0;
                last = c;
                n++;
            end
            pb = i2s_bclk;
        end
    endtask

    task automatic push(input logic [23:0] v);
        int n;
        n = 0;
        @(negedge clk);
        while (!din_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("push_ready", din_ready, 1);
        din       = v;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    // From the end of a frame, step to the clk just after the next frame load
    task automatic to_frame_start();
        int n;
        n = 0;
        while (i2s_bclk && n < 8) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 24'h000000, 1'b0, 1'b0, 24'hA5C3F1, 1'b0};
        vecs[1] = '{1'b1, 24'h123456, 1'b0, 1'b0, 24'h000000, 1'b1};
        vecs[2] = '{1'b1, 24'h800001, 1'b0, 1'b1, 24'h123456, 1'b0};
        vecs[3] = '{1'b1, 24'h7FFFFF, 1'b1, 1'b0, 24'h800001, 1'b0};
        vecs[4] = '{1'b1, 24'h000001, 1'b0, 1'b0, 24'h000000, 1'b0};
        vecs[5] = '{1'b0, 24'h000000, 1'b0, 1'b0, 24'h000001, 1'b0};
        vecs[6] = '{1'b0, 24'h000000, 1'b0, 1'b0, 24'h000000, 1'b1};

        reset = 1'b1; enable = 1'b1; mute = 1'b0;
        din = '0; din_valid = 1'b0; underflow_clear = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_bclk", i2s_bclk, 0);
        chk("rst_lrclk", i2s_lrclk, 0);
        chk("rst_sdata", i2s_sdata, 0);
        chk("rst_underflow", underflow, 0);
        chk("rst_din_ready", din_ready, 0);

        reset = 1'b0;
        @(negedge clk);
        chk("c1_bclk", i2s_bclk, 0);
        chk("c1_din_ready", din_ready, 1);
        din = 24'hA5C3F1; din_valid = 1'b1;
        @(negedge clk);
        chk("c2_bclk", i2s_bclk, 1);
        chk("c2_din_ready", din_ready, 0);
        din_valid = 1'b0;
        @(negedge clk);
        chk("c3_bclk", i2s_bclk, 1);
        @(negedge clk);
        chk("c4_fe_bclk", i2s_bclk, 0);
        chk("c4_lrclk", i2s_lrclk, 0);
        chk("c4_din_ready", din_ready, 1);
        chk("c4_underflow", underflow, 0);

        for (int i = 0; i < 7; i++) begin
            fork
                capture(bits, lrs, cyc, per_ok);
                begin
                    mute = vecs[i].mute_next;
                    if (vecs[i].push) push(vecs[i].val);
                    if (vecs[i].clr) begin
                        @(negedge clk);
                        underflow_clear = 1'b1;
                        @(negedge clk);
                        underflow_clear = 1'b0;
                    end
                end
            join
            chk($sformatf("frame%0d_data", i + 1), bits, frame_of(vecs[i].exp_val));
            chk($sformatf("frame%0d_lrclk", i + 1), lrs, {32'h0, 32'hFFFFFFFF});
            chk($sformatf("frame%0d_clks", i + 1), 64'(cyc), 64'd254);
            chk($sformatf("frame%0d_bclk_period", i + 1), per_ok, 1);
            chk($sformatf("frame%0d_underflow", i + 1), underflow, vecs[i].exp_uf);
            to_frame_start();
            chk($sformatf("frame%0d_boundary", i + 2), {i2s_bclk, i2s_lrclk}, 2'b00);
        end

        // Back-pressure: din_valid held high with an incrementing pattern
        stream_on = 1'b1;
        accepts   = 0;
        fork
            begin
                for (int f = 0; f < 4; f++) begin
                    capture(bits, lrs, cyc, per_ok);
                    fr[f] = bits;
                    if (f < 3) to_frame_start();
                end
                stream_on = 1'b0;
            end
            begin
                din       = 24'hFFFF00;
                din_valid = 1'b1;
                while (stream_on) begin
                    acc_pend = din_ready;
                    @(negedge clk);
                    if (acc_pend) begin
                        accepts++;
                        din = din + 24'd1;
                    end
                end
                din_valid = 1'b0;
            end
        join
        chk("bp_frame8", fr[0], frame_of(24'h000000));
        chk("bp_frame9", fr[1], frame_of(24'hFFFF00));
        chk("bp_frame10", fr[2], frame_of(24'hFFFF01));
        chk("bp_frame11", fr[3], frame_of(24'hFFFF02));
        chk("bp_accepts", 64'(accepts), 64'd4);
        to_frame_start();

        // Frame 12 carries FFFF03; hold a sample, then reset at right-slot bit 10
        push(24'h5A5A5A);
        rises  = 0;
        cyc    = 0;
        prev_b = i2s_bclk;
        while (rises < 43 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (i2s_bclk && !prev_b) rises++;
            prev_b = i2s_bclk;
        end
        chk("mr_rises", 64'(rises), 64'd43);
        chk("mr_pre_lrclk", i2s_lrclk, 1);
        chk("mr_pre_sdata", i2s_sdata, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("mr_bclk", i2s_bclk, 0);
        chk("mr_lrclk", i2s_lrclk, 0);
        chk("mr_sdata", i2s_sdata, 0);
        chk("mr_din_ready", din_ready, 0);
        chk("mr_underflow", underflow, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mr_c2_bclk", i2s_bclk, 1);
        @(negedge clk);
        underflow_clear = 1'b1;
        @(negedge clk);
        chk("uf_set_wins", underflow, 1);
        @(negedge clk);
        underflow_clear = 1'b0;
        chk("uf_clear_after", underflow, 0);
        capture(bits, lrs, cyc, per_ok);
        chk("mr_frame_discarded", bits, frame_of(24'h000000));
        chk("mr_frame_underflow", underflow, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
